// File: rtl/slt_iter.sv
// Multi-cycle set-less-than unit: compares a/b one DIGIT-wide chunk per cycle,
// MSB chunk first, stopping at the first differing chunk (SLT / SLTU + flags).
module slt_iter #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             aluc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             negative,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("slt_iter: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] la_reg;
    logic [WIDTH-1:0] lb_reg;
    logic             aluc_reg;
    logic [KW-1:0]    k_reg;
    logic             ult_reg;
    logic             eq_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             c0_reg;
    logic             carry_reg;
    logic             negative_reg;
    logic             zero_reg;

    logic [DIGIT-1:0] a_chunk [N];
    logic [DIGIT-1:0] b_chunk [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
        assign a_chunk[gi] = la_reg[gi*DIGIT +: DIGIT];
        assign b_chunk[gi] = lb_reg[gi*DIGIT +: DIGIT];
    end

    logic [DIGIT-1:0] a_cur;
    logic [DIGIT-1:0] b_cur;
    logic             sd;
    logic             slt;

    assign a_cur = a_chunk[k_reg];
    assign b_cur = b_chunk[k_reg];
    // Opposite signs decide a signed compare outright; otherwise unsigned order holds.
    assign sd    = la_reg[WIDTH-1] ^ lb_reg[WIDTH-1];
    assign slt   = sd ? la_reg[WIDTH-1] : ult_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            la_reg       <= '0;
            lb_reg       <= '0;
            aluc_reg     <= 1'b0;
            k_reg        <= '0;
            ult_reg      <= 1'b0;
            eq_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            c0_reg       <= 1'b0;
            carry_reg    <= 1'b0;
            negative_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        la_reg    <= a;
                        lb_reg    <= b;
                        aluc_reg  <= aluc;
                        k_reg     <= KW'(N - 1);
                        busy_reg  <= 1'b1;
                        state_reg <= CMP;
                    end
                end
                CMP: begin
                    if (a_cur != b_cur) begin
                        ult_reg   <= (a_cur < b_cur);
                        eq_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else if (k_reg == '0) begin
                        ult_reg   <= 1'b0;
                        eq_reg    <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg - 1'b1;
                    end
                end
                DONE: begin
                    c0_reg       <= aluc_reg ? ult_reg : slt;
                    carry_reg    <= ult_reg;
                    negative_reg <= slt;
                    zero_reg     <= eq_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign c        = {{(WIDTH-1){1'b0}}, c0_reg};
    assign carry    = carry_reg;
    assign negative = negative_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_slt_iter.sv
// Directed and randomised checks of slt_iter at DIGIT = 8, 1 and 32.
module tb_slt_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0][31:0] a_v;
    logic [2:0][31:0] b_v;
    logic [2:0]  aluc_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0][31:0] c_v;
    logic [2:0]  carry_v;
    logic [2:0]  neg_v;
    logic [2:0]  zero_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    slt_iter #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .aluc(aluc_v[0]), .busy(busy_v[0]), .done(done_v[0]), .c(c_v[0]),
        .carry(carry_v[0]), .negative(neg_v[0]), .zero(zero_v[0]));

    slt_iter #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .aluc(aluc_v[1]), .busy(busy_v[1]), .done(done_v[1]), .c(c_v[1]),
        .carry(carry_v[1]), .negative(neg_v[1]), .zero(zero_v[1]));

    slt_iter #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .aluc(aluc_v[2]), .busy(busy_v[2]), .done(done_v[2]), .c(c_v[2]),
        .carry(carry_v[2]), .negative(neg_v[2]), .zero(zero_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int digit_of(input int idx);
        return (idx == 0) ? 8 : (idx == 1) ? 1 : 32;
    endfunction

    // Edges from accept to done: N - j + 1, j = highest differing chunk (0 if equal).
    function automatic int exp_lat(input int d, input logic [31:0] x, input logic [31:0] y);
        int n = 32 / d;
        int j = 0;
        logic [63:0] m = (64'd1 << d) - 64'd1;
        logic [63:0] df = {32'd0, x ^ y};
        for (int k = 0; k < n; k++)
            if (((df >> (k * d)) & m) != 64'd0) j = k;
        return n - j + 1;
    endfunction

    // Called #1 after a rising edge; the next edge accepts the request.
    task automatic run(input int idx, input logic [31:0] av, input logic [31:0] bv,
                       input logic al, input bit keep, input bit scramble, input string tag);
        int n;
        logic ult, slt;
        a_v[idx] = av; b_v[idx] = bv; aluc_v[idx] = al; start_v[idx] = 1'b1;
        @(posedge clk); #1;
        chk({tag, " busy"}, {31'd0, busy_v[idx]}, 32'd1);
        if (!keep) start_v[idx] = 1'b0;
        if (scramble) begin
            a_v[idx] = $urandom; b_v[idx] = $urandom; aluc_v[idx] = ~al;
        end
        n = 0;
        while (!done_v[idx] && n < 60) begin
            @(posedge clk); #1; n++;
        end
        ult = (av < bv);
        slt = ($signed(av) < $signed(bv));
        chk({tag, " latency"}, n, exp_lat(digit_of(idx), av, bv));
        chk({tag, " c"}, c_v[idx], {31'd0, al ? ult : slt});
        chk({tag, " carry"}, {31'd0, carry_v[idx]}, {31'd0, ult});
        chk({tag, " negative"}, {31'd0, neg_v[idx]}, {31'd0, slt});
        chk({tag, " zero"}, {31'd0, zero_v[idx]}, {31'd0, av == bv});
        if (scramble) begin
            a_v[idx] = av; b_v[idx] = bv; aluc_v[idx] = al;
        end
    endtask

    initial begin
        int first, pulses;
        logic [31:0] ra, rb;
        start_v = '0; a_v = '0; b_v = '0; aluc_v = '0;
        rst_n = 1'b0;
        #1;
        chk("reset busy", {29'd0, busy_v}, 32'd0);
        chk("reset done", {29'd0, done_v}, 32'd0);
        chk("reset c", c_v[0], 32'd0);
        chk("reset flags", {29'd0, carry_v[0], neg_v[0], zero_v[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the DIGIT=8 instance
        run(0, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, "t1");
        chk("t1 lat5", exp_lat(8, 32'd5, 32'd7), 5);
        @(posedge clk); #1;
        chk("t1 done pulse", {31'd0, done_v[0]}, 32'd0);
        chk("t1 hold c", c_v[0], 32'd1);
        run(0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, "t2s");
        run(0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0, "t2u");
        run(0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, "t3");
        run(0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0, "t3b");
        run(0, 32'h12345600, 32'h123456FF, 1'b1, 1'b0, 1'b0, "t3c");

        // Second start during CMP must be ignored; operands changing must not matter
        a_v[0] = 32'd1; b_v[0] = 32'd2; aluc_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        first = 0; pulses = 0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (e == 2) begin
                a_v[0] = 32'd9; b_v[0] = 32'd3; start_v[0] = 1'b1;
            end else if (e == 3) begin
                start_v[0] = 1'b0; a_v[0] = 32'hDEAD; b_v[0] = 32'h1;
            end
            if (done_v[0]) begin
                pulses++;
                if (first == 0) begin
                    first = e;
                    chk("t4 c", c_v[0], 32'd1);
                end
            end
        end
        chk("t4 first done edge", first, 5);
        chk("t4 done pulses", pulses, 1);

        // Asynchronous abort two cycles into CMP
        a_v[0] = 32'd5; b_v[0] = 32'd7; aluc_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 busy", {31'd0, busy_v[0]}, 32'd0);
        chk("t5 done", {31'd0, done_v[0]}, 32'd0);
        chk("t5 c", c_v[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done_v[0]) pulses++;
        end
        chk("t5 no done after abort", pulses, 0);
        run(0, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, "t5z");

        // Random sweep with start held high: back-to-back issue after each done
        for (int idx = 0; idx < 3; idx++) begin
            for (int i = 0; i < 600; i++) begin
                ra = $urandom;
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1, 2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                    default: rb = $urandom;
                endcase
                run(idx, ra, rb, 1'(($urandom >> 3) & 1), 1'b1, 1'b1, "rnd");
            end
            start_v[idx] = 1'b0;
            repeat (40) @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
